// File: rtl/paddle_ctrl.sv
// Per-player paddle position controller: synchronizes the up/down commands and moves each paddle once per game tick, accelerating on held direction and clamping at the walls.
// Latency: commands act on the first tick at least two clk edges after they settle; outputs and update register on the tick edge. No backpressure.
module paddle_ctrl #(
    parameter int SCREEN_H    = 480,
    parameter int PADDLE_H    = 64,
    parameter int Y_W         = 10,
    parameter int STEP        = 4,
    parameter int ACCEL_TICKS = 8,
    parameter int TICK_DIV    = 833333
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [1:0]     tclock1,
    input  logic [1:0]     tclock2,
    output logic [Y_W-1:0] paddle1_y,
    output logic [Y_W-1:0] paddle2_y,
    output logic           update
);
    localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int CNT_W = $clog2(ACCEL_TICKS + 1);

    localparam logic [Y_W-1:0]   Y_MAX    = Y_W'(SCREEN_H - PADDLE_H);
    localparam logic [Y_W-1:0]   Y_INIT   = Y_W'((SCREEN_H - PADDLE_H) / 2);
    localparam logic [Y_W-1:0]   STEP_N   = Y_W'(STEP);
    localparam logic [Y_W-1:0]   STEP_F   = Y_W'(2 * STEP);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(ACCEL_TICKS);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

    localparam logic [1:0] DIR_NONE = 2'b00;
    localparam logic [1:0] DIR_UP   = 2'b01;
    localparam logic [1:0] DIR_DN   = 2'b10;

    logic [1:0][1:0]       w_cmd;
    logic [1:0][1:0]       r_meta;
    logic [1:0][1:0]       r_sync;
    logic [DIV_W-1:0]      r_div;
    logic                  w_tick;
    logic                  r_update;

    logic [1:0][Y_W-1:0]   r_y;
    logic [1:0][CNT_W-1:0] r_cnt;
    logic [1:0][1:0]       r_last;

    logic [1:0][1:0]       w_dir;
    logic [1:0][Y_W-1:0]   w_step;
    logic [1:0][Y_W:0]     w_sum;
    logic [1:0][Y_W-1:0]   w_y_nxt;
    logic [1:0][CNT_W-1:0] w_cnt_nxt;
    logic [1:0][1:0]       w_last_nxt;

    assign w_cmd  = {tclock2, tclock1};
    assign w_tick = (r_div == DIV_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= '0;
            r_sync <= '0;
            r_div  <= '0;
        end else begin
            r_meta <= w_cmd;
            r_sync <= r_meta;
            r_div  <= w_tick ? '0 : r_div + 1'b1;
        end
    end

    // Paddle index 0 is player 1, index 1 is player 2; both share one decode.
    always_comb begin
        w_dir      = '0;
        w_step     = '0;
        w_sum      = '0;
        w_y_nxt    = r_y;
        w_cnt_nxt  = r_cnt;
        w_last_nxt = r_last;
        for (int p = 0; p < 2; p++) begin
            w_dir[p] = (r_sync[p] == DIR_UP || r_sync[p] == DIR_DN) ? r_sync[p] : DIR_NONE;
            if (w_dir[p] == DIR_NONE) begin
                w_cnt_nxt[p]  = '0;
                w_last_nxt[p] = DIR_NONE;
            end else begin
                if (w_dir[p] == r_last[p]) begin
                    w_step[p]    = (r_cnt[p] == CNT_MAX) ? STEP_F : STEP_N;
                    w_cnt_nxt[p] = (r_cnt[p] == CNT_MAX) ? CNT_MAX : r_cnt[p] + CNT_W'(1);
                end else begin
                    w_step[p]     = STEP_N;
                    w_cnt_nxt[p]  = CNT_W'(1);
                    w_last_nxt[p] = w_dir[p];
                end
                // Extra bit keeps the downward sum from wrapping before the clamp.
                w_sum[p] = {1'b0, r_y[p]} + {1'b0, w_step[p]};
                if (w_dir[p] == DIR_UP) begin
                    w_y_nxt[p] = (r_y[p] < w_step[p]) ? '0 : r_y[p] - w_step[p];
                end else begin
                    w_y_nxt[p] = (w_sum[p] > {1'b0, Y_MAX}) ? Y_MAX : w_sum[p][Y_W-1:0];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_y      <= {Y_INIT, Y_INIT};
            r_cnt    <= '0;
            r_last   <= '0;
            r_update <= 1'b0;
        end else begin
            r_update <= w_tick;
            if (w_tick) begin
                r_y    <= w_y_nxt;
                r_cnt  <= w_cnt_nxt;
                r_last <= w_last_nxt;
            end
        end
    end

    assign paddle1_y = r_y[0];
    assign paddle2_y = r_y[1];
    assign update    = r_update;
endmodule

// File: tb/tb_paddle_ctrl.sv
// Directed bench for paddle_ctrl with a 4-cycle tick, step 4 and fast speed after 3 ticks.
module tb_paddle_ctrl;
    logic       clk;
    logic       rst_n;
    logic [1:0] tclock1;
    logic [1:0] tclock2;
    logic [9:0] paddle1_y;
    logic [9:0] paddle2_y;
    logic       update;

    int checks = 0;
    int errors = 0;

    paddle_ctrl #(
        .SCREEN_H(480), .PADDLE_H(64), .Y_W(10),
        .STEP(4), .ACCEL_TICKS(3), .TICK_DIV(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .tclock1(tclock1), .tclock2(tclock2),
        .paddle1_y(paddle1_y), .paddle2_y(paddle2_y), .update(update)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    task automatic wait_tick();
        int n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (update !== 1'b1 && n < 8);
        checks++;
        if (update !== 1'b1) begin
            errors++;
            $display("FAIL tick_timeout update=%b expected 1", update);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b1; tclock1 = 2'b00; tclock2 = 2'b00;
        #1 rst_n = 1'b0;
        #2;
        checks++;
        if (paddle1_y !== 10'd208 || paddle2_y !== 10'd208 || update !== 1'b0) begin
            errors++;
            $display("FAIL reset_state p1=%0d p2=%0d upd=%b expected 208 208 0", paddle1_y, paddle2_y, update);
        end
        #27 rst_n = 1'b1;
        for (int e = 1; e <= 4; e++) begin
            @(posedge clk); #1;
            checks++;
            if (update !== (e == 4) || paddle1_y !== 10'd208 || paddle2_y !== 10'd208) begin
                errors++;
                $display("FAIL first_tick edge=%0d upd=%b p1=%0d p2=%0d expected upd=%0d 208 208",
                         e, update, paddle1_y, paddle2_y, (e == 4));
            end
        end
        for (int e = 1; e <= 4; e++) begin
            @(posedge clk); #1;
            checks++;
            if (update !== (e == 4) || paddle1_y !== 10'd208 || paddle2_y !== 10'd208) begin
                errors++;
                $display("FAIL idle_tick edge=%0d upd=%b p1=%0d p2=%0d expected upd=%0d 208 208",
                         e, update, paddle1_y, paddle2_y, (e == 4));
            end
        end
        @(posedge clk); #1;
        checks++;
        if (update !== 1'b0) begin
            errors++;
            $display("FAIL update_width upd=%b expected 0", update);
        end
    endtask

    task automatic test_up_hold();
        int exp_y [5] = '{204, 200, 196, 188, 180};
        tclock1 = 2'b01;
        for (int t = 0; t < 5; t++) begin
            wait_tick();
            checks++;
            if (paddle1_y !== 10'(exp_y[t]) || paddle2_y !== 10'd208) begin
                errors++;
                $display("FAIL up_hold tick=%0d p1=%0d p2=%0d expected %0d 208", t, paddle1_y, paddle2_y, exp_y[t]);
            end
        end
        tclock1 = 2'b00;
    endtask

    task automatic test_reset_mid();
        checks++;
        if (paddle1_y !== 10'd180) begin
            errors++;
            $display("FAIL mid_pre p1=%0d expected 180", paddle1_y);
        end
        @(posedge clk); #1;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (paddle1_y !== 10'd208 || paddle2_y !== 10'd208 || update !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset p1=%0d p2=%0d upd=%b expected 208 208 0", paddle1_y, paddle2_y, update);
        end
        @(posedge clk); @(posedge clk);
        #3 rst_n = 1'b1;
        for (int e = 1; e <= 4; e++) begin
            @(posedge clk); #1;
            checks++;
            if (update !== (e == 4) || paddle1_y !== 10'd208) begin
                errors++;
                $display("FAIL mid_release edge=%0d upd=%b p1=%0d expected upd=%0d 208", e, update, paddle1_y, (e == 4));
            end
        end
    endtask

    task automatic test_down_sat();
        int first [4] = '{212, 216, 220, 228};
        int exp_y;
        tclock2 = 2'b10;
        for (int t = 0; t < 30; t++) begin
            if (t < 4) exp_y = first[t];
            else exp_y = (exp_y + 8 > 416) ? 416 : exp_y + 8;
            wait_tick();
            checks++;
            if (paddle2_y !== 10'(exp_y) || paddle1_y !== 10'd208) begin
                errors++;
                $display("FAIL down_sat tick=%0d p2=%0d p1=%0d expected %0d 208", t, paddle2_y, paddle1_y, exp_y);
            end
        end
        tclock2 = 2'b00;
    endtask

    task automatic test_reverse();
        int exp_y [7] = '{204, 200, 196, 188, 188, 192, 196};
        for (int t = 0; t < 7; t++) begin
            tclock1 = (t < 4) ? 2'b01 : (t == 4) ? 2'b11 : 2'b10;
            wait_tick();
            checks++;
            if (paddle1_y !== 10'(exp_y[t]) || paddle2_y !== 10'd416) begin
                errors++;
                $display("FAIL reverse tick=%0d p1=%0d p2=%0d expected %0d 416", t, paddle1_y, paddle2_y, exp_y[t]);
            end
        end
        tclock1 = 2'b00;
    endtask

    task automatic test_both();
        rst_n = 1'b0;
        #3 rst_n = 1'b1;
        wait_tick();
        tclock1 = 2'b01;
        tclock2 = 2'b10;
        for (int e = 1; e <= 5; e++) begin
            @(posedge clk); #1;
            checks++;
            if (e < 4 && (update !== 1'b0 || paddle1_y !== 10'd208 || paddle2_y !== 10'd208)) begin
                errors++;
                $display("FAIL both_pre edge=%0d upd=%b p1=%0d p2=%0d expected 0 208 208", e, update, paddle1_y, paddle2_y);
            end else if (e == 4 && (update !== 1'b1 || paddle1_y !== 10'd204 || paddle2_y !== 10'd212)) begin
                errors++;
                $display("FAIL both_tick upd=%b p1=%0d p2=%0d expected 1 204 212", update, paddle1_y, paddle2_y);
            end else if (e == 5 && (update !== 1'b0 || paddle1_y !== 10'd204 || paddle2_y !== 10'd212)) begin
                errors++;
                $display("FAIL both_post upd=%b p1=%0d p2=%0d expected 0 204 212", update, paddle1_y, paddle2_y);
            end
        end
        tclock1 = 2'b00;
        tclock2 = 2'b00;
    endtask

    initial begin
        test_reset();
        test_up_hold();
        test_reset_mid();
        test_down_sat();
        test_reverse();
        test_both();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/paddle_ctrl.md
# paddle_ctrl

Per-player paddle position controller for the Pong datapath. Consumes the two 2-bit paddle command buses (`tclock1`, `tclock2`) produced by the paddle input stage and turns them into clamped vertical paddle positions, updated once per game tick. Position outputs feed the renderer and the ball/collision logic directly.

## Interface
Parameters:
- `SCREEN_H`, 480, visible screen height in pixels
- `PADDLE_H`, 64, paddle height in pixels
- `Y_W`, 10, width of the position outputs
- `STEP`, 4, pixels moved per tick at normal speed
- `ACCEL_TICKS`, 8, consecutive same-direction ticks before fast speed (2*STEP)
- `TICK_DIV`, 833333, clock cycles per game tick (60 Hz at 50 MHz)

Ports:
- `clk`  in  1  system clock; the only clock
- `rst_n`  in  1  asynchronous, active-low reset
- `tclock1`  in  2  player 1 command: bit0 = up, bit1 = down
- `tclock2`  in  2  player 2 command: same encoding
- `paddle1_y`  out  Y_W  player 1 paddle top edge, 0 = screen top
- `paddle2_y`  out  Y_W  player 2 paddle top edge
- `update`  out  1  one-cycle pulse; positions just changed (or were re-evaluated)

## Operation
- Inputs are asynchronous to game logic: each command bit passes through a 2-flop synchronizer (reset to 0).
- Tick prescaler: counter 0..TICK_DIV-1, wraps to 0; the tick is the cycle where the count equals TICK_DIV-1.
- Direction decode per paddle, from synchronized bits: 01 = up, 10 = down, 00 or 11 = hold.
- Per-paddle hold counter `cnt`, 0..ACCEL_TICKS, saturating. States derived from it: IDLE (cnt=0), MOVE (0<cnt<ACCEL_TICKS), FAST (cnt=ACCEL_TICKS).
- On each tick, for each paddle independently:
  - hold: position unchanged, cnt←0, last direction cleared.
  - Direction equal to last direction: step = (cnt==ACCEL_TICKS) ? 2*STEP : STEP, then cnt←min(cnt+1, ACCEL_TICKS).
  - Direction differing from last direction (including from IDLE): step = STEP, cnt←1, last direction←new.
  - up: y←(y<step) ? 0 : y-step.
  - down: y←(y+step > SCREEN_H-PADDLE_H) ? SCREEN_H-PADDLE_H : y+step. Compute the sum in Y_W+1 bits so there is no wrap.
  - Clamping at a wall does not reset cnt or the state.
- Positions are never outside 0..SCREEN_H-PADDLE_H.
- Reset (async, any time): synchronizers 0, prescaler 0, cnt 0, last direction cleared, `paddle1_y`=`paddle2_y`=(SCREEN_H-PADDLE_H)/2 (208 at defaults), `update`=0. All of this takes effect immediately, without a clock edge.

## Timing
- Command latency: a command bit must be stable at the input for ≥2 clk edges before the tick edge to be used on that tick.
- On the tick edge, both positions register their new values. `update` is registered on the same edge, so it is high for exactly one cycle while the new values are on the outputs.
- `update` pulses every tick, even when neither position changes.
- First tick after reset release: TICK_DIV cycles after the first active edge.
- Outputs change only on tick edges (or reset); between ticks they are stable.
- Simultaneous events: both paddles update on the same edge. A command change on the tick edge itself uses the previously synchronized value.

## Test plan
Bench parameters: TICK_DIV=4, STEP=4, ACCEL_TICKS=3; other parameters at default (max y=416, init=208).
- Reset release with both commands 00 -> `paddle1_y`=`paddle2_y`=208 and `update`=0 at release; `update` pulses every 4 cycles with both positions remaining 208.
- `tclock1`=01 held -> `paddle1_y` sequence on successive ticks is 204, 200, 196, 188, 180; `paddle2_y` stays 208.
- `tclock2`=10 held from 208 -> positions rise 212, 216, 220, 228, … and saturate at 416; further ticks hold 416 with `update` still pulsing.
- `tclock1`=01 until FAST (y=188), then 11 for one tick, then 10 -> 188 on the 11 tick, then 192, 196 (step back to 4, counter restarted).
- `rst_n` driven low mid-prescale with `paddle1_y`=180 -> both outputs 208 and `update`=0 immediately (no clk edge); after release, the next tick comes a full 4 cycles later.
- `tclock1`=01 and `tclock2`=10 applied together -> both paddles move on the same tick edge (204 and 212) with a single `update` pulse.
